mem_port_arbiter: RTL and testbench

Parametrised single-port memory arbiter that replaces clock-phase multiplexing of instruction fetch and data access onto the unified `Memory`. N requesters (fetch, load/store, later DMA/debug) compete for one synchronous memory port each cycle under fixed-priority or round-robin arbitration. The block handles byte/half/word sizing, byte enables, load alignment and sign extension, and routes returning read data to its owner after a configurable memory latency. It sits between the pipeline stages (IF, MEM) and the memory macro, all on a single clock.

---
 rtl/mem_arb_pkg.sv | 53 +++++
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the memory port arbiter and its load aligner.
package mem_arb_pkg;

  // Access size encoding carried on the per-requester size field.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  // Owner field is sized for up to 16 requesters.
  localparam int OWNER_W = 4;

  // Load tag travelling alongside the memory read latency.
  typedef struct packed {
    logic               vld;
    logic [OWNER_W-1:0] owner;
    size_e              sz;
    logic               sgn;
    logic [1:0]         off;
  } tag_t;

  // Natural alignment check; the illegal size code is never aligned.
  function automatic logic is_aligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return ~off[0];
      SZ_W:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate LSB-aligned store data across all byte lanes.
  function automatic logic [31:0] lane_rep(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Shifts, masks and extends a raw memory word into LSB-aligned load data.
module mem_load_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] i_data,
  input  size_e       i_size,
  input  logic        i_sgn,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;

  assign w_shift = i_data >> {i_off, 3'b000};

  // Select the addressed field and extend it to 32 bits.
  // NOTE: every path assigns o_data, so no latch is inferred.
  always_comb begin
    case (i_size)
      SZ_B:    o_data = {{24{i_sgn & w_shift[7]}}, w_shift[7:0]};
      SZ_H:    o_data = {{16{i_sgn & w_shift[15]}}, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one grant per cycle, command formatting toward the
// memory macro and latency-matched routing of read data back to its owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 8,
  parameter int RR      = 1,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [2*N_REQ-1:0]      size,
  input  logic [N_REQ-1:0]        sgn,
  input  logic [ADDR_W*N_REQ-1:0] addr,
  input  logic [32*N_REQ-1:0]     wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        err,
  output logic [N_REQ-1:0]        rvalid,
  output logic [31:0]             rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_W-3:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] r_last_gnt;
  logic             r_run;
  tag_t             r_tag [MEM_LAT];

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic             w_grant;
  logic             w_legal;
  size_e            w_size;
  logic [1:0]       w_off;
  logic [N_REQ-1:0] w_onehot;
  tag_t             w_tag_in;
  tag_t             w_tag_out;
  logic [31:0]      w_aligned;

  // k-th candidate in scan order: circular after the last grant, or plain index order.
  function automatic logic [IDX_W-1:0] scan_idx(input int k, input logic [IDX_W-1:0] last);
    return IDX_W'((RR != 0) ? ((int'(last) + 1 + k) % N_REQ) : k);
  endfunction

  // Pick the first requesting index in scan order.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[scan_idx(k, r_last_gnt)]) begin
        w_found = 1'b1;
        w_idx   = scan_idx(k, r_last_gnt);
      end
    end
  end

  // Grants are held off until the first edge after reset release.
  assign w_grant  = w_found & r_run;
  assign w_size   = size_e'(size[2*w_idx +: 2]);
  assign w_off    = addr[ADDR_W*w_idx +: 2];
  assign w_legal  = is_aligned(w_size, w_off);
  assign w_onehot = N_REQ'(1) << w_idx;

  // Drive grant/error and the memory command for the winning requester.
  always_comb begin
    gnt       = '0;
    err       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant) begin
      gnt = w_onehot;
      if (!w_legal) begin
        err = w_onehot;
      end else begin
        mem_en   = 1'b1;
        mem_addr = addr[ADDR_W*w_idx + 2 +: ADDR_W-2];
        if (we[w_idx]) begin
          mem_we    = 1'b1;
          mem_be    = byte_en(w_size, w_off);
          mem_wdata = lane_rep(w_size, wdata[32*w_idx +: 32]);
        end
      end
    end
  end

  assign w_tag_in = '{vld:   mem_en & ~mem_we,
                      owner: OWNER_W'(w_idx),
                      sz:    w_size,
                      sgn:   sgn[w_idx],
                      off:   w_off};

  // Arbitration history, run enable and the load-tag delay line.
  // NOTE: the whole tag line is cleared on reset so in-flight loads never return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run      <= 1'b0;
      r_last_gnt <= IDX_W'(N_REQ - 1);
      for (int i = 0; i < MEM_LAT; i++) r_tag[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      r_run <= 1'b1;
      if (w_grant) r_last_gnt <= w_idx;
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < MEM_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_out = r_tag[MEM_LAT-1];

  mem_load_align u_align (
    .i_data (mem_rdata),
    .i_size (w_tag_out.sz),
    .i_sgn  (w_tag_out.sgn),
    .i_off  (w_tag_out.off),
    .o_data (w_aligned)
  );

  assign rvalid = w_tag_out.vld ? (N_REQ'(1) << w_tag_out.owner) : '0;
  assign rdata  = w_tag_out.vld ? w_aligned : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (scan order, byte arithmetic, return queue).
module tb_mem_port_arbiter;

  localparam int N   = 2;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, we, sgn;
  logic [2*N-1:0]  size;
  logic [AW*N-1:0] addr;
  logic [32*N-1:0] wdata;
  logic [N-1:0]  gnt, err, rvalid;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-3:0] mem_addr;

  logic [N-1:0]  fp_req, fp_gnt, fp_err, fp_rvalid;
  logic [31:0]   fp_rdata, fp_mem_wdata;
  logic          fp_mem_en, fp_mem_we;
  logic [3:0]    fp_mem_be;
  logic [AW-3:0] fp_mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .RR(1), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sgn(sgn), .addr(addr),
    .wdata(wdata), .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .RR(0), .MEM_LAT(1)) u_fp (
    .clk(clk), .rst(rst), .req(fp_req), .we(we), .size(size), .sgn(sgn), .addr(addr),
    .wdata(wdata), .gnt(fp_gnt), .err(fp_err), .rvalid(fp_rvalid), .rdata(fp_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_be(fp_mem_be), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(32'h0)
  );

  // Memory macro: byte-enabled writes, reads returned LAT cycles after the command.
  logic [31:0] mem [64];
  logic [31:0] rd_pipe [LAT];
  logic [31:0] ref_mem [64];
  logic        load_mem;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model state.
  typedef struct { int owner; int due; logic [31:0] val; } ret_t;
  ret_t exp_q[$];
  int   last, cyc;
  bit   armed;
  bit   cur_found, cur_ok;
  int   cur_g;
  logic [N-1:0]  e_gnt, e_err, e_rv;
  logic          e_en, e_we;
  logic [3:0]    e_be;
  logic [31:0]   e_wd, e_rd;
  logic [AW-3:0] e_addr;
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit legal(input int sz, input int a);
    return (sz != 3) && ((a % (1 << sz)) == 0);
  endfunction

  task automatic set_cmd(input int r, input bit w, input int sz, input bit s, input int a,
                         input logic [31:0] d);
    we[r]              = w;
    size[2*r +: 2]     = 2'(sz);
    sgn[r]             = s;
    addr[AW*r +: AW]   = AW'(a);
    wdata[32*r +: 32]  = d;
  endtask

  task automatic rand_cmd(input int r);
    int v, sz, a;
    v  = $urandom_range(0, 9);
    sz = (v < 3) ? 0 : (v < 6) ? 1 : (v < 9) ? 2 : 3;
    a  = $urandom_range(0, 255);
    if (sz != 3 && $urandom_range(0, 9) < 7) a = a - (a % (1 << sz));
    set_cmd(r, 1'($urandom), sz, 1'($urandom), a, $urandom);
  endtask

  // Mid-cycle: predict this cycle's outputs and compare.
  task automatic sample();
    int sz, a, nb;
    logic [31:0] d;
    @(negedge clk);
    e_gnt = '0; e_err = '0; e_rv = '0; e_en = 1'b0; e_we = 1'b0;
    e_be = '0; e_wd = '0; e_rd = '0; e_addr = '0;
    cur_found = 1'b0; cur_ok = 1'b0; cur_g = 0;
    if (!rst) begin
      exp_q.delete();
      last  = N - 1;
      armed = 1'b0;
    end else if (armed) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (last + 1 + k) % N;
        if (!cur_found && req[c]) begin cur_found = 1'b1; cur_g = c; end
      end
    end
    if (cur_found) begin
      sz     = int'(size[2*cur_g +: 2]);
      a      = int'(addr[AW*cur_g +: AW]);
      d      = wdata[32*cur_g +: 32];
      cur_ok = legal(sz, a);
      e_gnt  = N'(1 << cur_g);
      if (!cur_ok) e_err = e_gnt;
      else begin
        e_en   = 1'b1;
        e_addr = (AW-2)'(a >> 2);
        if (we[cur_g]) begin
          nb   = 1 << sz;
          e_we = 1'b1;
          e_be = 4'(((1 << nb) - 1) << (a % 4));
          for (int b = 0; b < 4; b++) e_wd[8*b +: 8] = d[8*(b % nb) +: 8];
        end
      end
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_rv = N'(1 << exp_q[0].owner);
      e_rd = exp_q[0].val;
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("err", 32'(err), 32'(e_err));
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) begin
      check("mem_be", 32'(mem_be), 32'(e_be));
      check("mem_wdata", mem_wdata, e_wd);
    end
    check("rvalid", 32'(rvalid), 32'(e_rv));
    if (e_rv != '0 || !rst) check("rdata", rdata, e_rd);
    if (!rst) check("rst_mem_be", 32'(mem_be), 32'h0);
  endtask

  // Clock edge: commit the predicted access into the model.
  task automatic advance();
    int sz, a, nb;
    logic [31:0] v, m;
    @(posedge clk);
    if (rst && cur_found) begin
      last = cur_g;
      if (cur_ok) begin
        sz = int'(size[2*cur_g +: 2]);
        a  = int'(addr[AW*cur_g +: AW]);
        nb = 1 << sz;
        if (we[cur_g]) begin
          for (int b = 0; b < 4; b++)
            if (e_be[b]) ref_mem[a >> 2][8*b +: 8] = e_wd[8*b +: 8];
        end else begin
          v = ref_mem[a >> 2] >> (8 * (a % 4));
          if (nb < 4) begin
            m = (32'd1 << (8 * nb)) - 32'd1;
            v = v & m;
            if (sgn[cur_g] && v[8*nb-1]) v = v | ~m;
          end
          exp_q.push_back('{cur_g, cyc + LAT, v});
        end
      end
    end
    if (rst) armed = 1'b1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) begin sample(); advance(); end
  endtask

  initial begin
    rst = 1'b0; load_mem = 1'b1; req = '0; fp_req = '0;
    we = '0; sgn = '0; size = '0; addr = '0; wdata = '0;
    last = N - 1; cyc = 0; armed = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    // Requests held during reset must not be granted.
    set_cmd(0, 0, 2, 0, 8'h00, 0);
    set_cmd(1, 0, 2, 0, 8'h04, 0);
    req = 2'b11;
    sample();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    advance();
    load_mem = 1'b0;
    rst = 1'b1;
    req = '0;
    sample(); advance();

    // Round robin with both requesters held: 0 first, then alternate.
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("rr_seq", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      advance();
    end
    idle(3);

    // Byte store then signed/unsigned byte loads at 0x13.
    set_cmd(0, 1, 0, 0, 8'h13, 32'h000000A5);
    req = 2'b01;
    sample();
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    advance();
    for (int s = 1; s >= 0; s--) begin
      set_cmd(1, 0, 0, 1'(s), 8'h13, 0);
      req = 2'b10;
      sample(); advance();
      req = '0;
      sample(); check("lb_gap", 32'(rvalid), 32'h0); advance();
      sample();
      check("lb_rvalid", 32'(rvalid), 32'h2);
      check("lb_rdata", rdata, (s == 1) ? 32'hFFFFFFA5 : 32'h000000A5);
      advance();
    end

    // Signed half load from word 0x80017FFF.
    set_cmd(0, 1, 2, 0, 8'h00, 32'h80017FFF);
    req = 2'b01;
    sample(); advance();
    set_cmd(0, 0, 1, 1, 8'h02, 0);
    sample(); advance();
    idle(1);
    sample();
    check("lh_rvalid", 32'(rvalid), 32'h1);
    check("lh_rdata", rdata, 32'hFFFF8001);
    advance();

    // Misaligned word load: error pulse, no memory access, no return.
    set_cmd(1, 0, 2, 0, 8'h05, 0);
    req = 2'b10;
    sample();
    check("mis_err", 32'(err), 32'h2);
    check("mis_en", 32'(mem_en), 32'h0);
    advance();
    idle(1);
    sample(); check("mis_norv", 32'(rvalid), 32'h0); advance();

    // Back-to-back loads with a one-cycle reset after the second.
    idle(2);
    req = 2'b01;
    set_cmd(0, 0, 2, 0, 8'h10, 0); sample(); advance();
    set_cmd(0, 0, 2, 0, 8'h14, 0); sample(); advance();
    set_cmd(0, 0, 2, 0, 8'h18, 0);
    rst = 1'b0;
    sample();
    check("mid_gnt", 32'(gnt), 32'h0);
    check("mid_rvalid", 32'(rvalid), 32'h0);
    check("mid_rdata", rdata, 32'h0);
    check("mid_en", 32'(mem_en), 32'h0);
    advance();
    rst = 1'b1;
    sample();
    check("rel_gnt", 32'(gnt), 32'h0);
    check("rel_rvalid", 32'(rvalid), 32'h0);
    advance();
    sample(); check("post_gnt", 32'(gnt), 32'h1); advance();
    idle(1);
    sample(); check("post_rvalid", 32'(rvalid), 32'h1); advance();

    // Fixed priority: requester 1 starves until requester 0 drops.
    idle(1);
    set_cmd(0, 0, 2, 0, 8'h20, 0);
    set_cmd(1, 0, 2, 0, 8'h24, 0);
    fp_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      sample(); check("fp_starve", 32'(fp_gnt), 32'h1); advance();
    end
    fp_req = 2'b10;
    sample(); check("fp_release", 32'(fp_gnt), 32'h2); advance();
    fp_req = '0;

    // Alternating fetch/load traffic.
    set_cmd(0, 0, 2, 0, 8'h20, 0);
    set_cmd(1, 0, 0, 1, 8'h21, 0);
    for (int i = 0; i < 6; i++) begin
      req = (i % 2 == 0) ? 2'b01 : 2'b10;
      sample(); advance();
    end
    idle(3);

    // Random traffic: commands held until granted, occasional withdrawal.
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < N; r++) begin
        if (!req[r] || (cur_found && cur_g == r)) begin
          if ($urandom_range(0, 9) < 7) begin rand_cmd(r); req[r] = 1'b1; end
          else req[r] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          req[r] = 1'b0;
        end
      end
      sample(); advance();
    end
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
